// File: rtl/alu_rr_scheduler.sv
// Round-robin front end for one shared add/sub/and/or datapath.
// A winner's operands are captured, executed once, and returned with its index.
module alu_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WIDTH-1:0]     a_in,
  input  logic [N_REQ*WIDTH-1:0]     b_in,
  input  logic [2*N_REQ-1:0]         op_in,
  output logic [N_REQ-1:0]           gnt,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(N_REQ)-1:0]   done_id,
  output logic [WIDTH-1:0]           result,
  output logic                       carry,
  output logic                       zero
);

  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   pick;
  logic [ID_W-1:0]   cand;
  logic              found;
  int                idx;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [1:0]        op_q;
  logic [WIDTH:0]    alu;

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  // Search upward from the priority pointer, wrapping, and take the first request.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx  = (int'(ptr) + i) % N_REQ;
      cand = ID_W'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // The extra top bit is carry-out for add and borrow for sub.
  always_comb begin
    alu = '0;
    case (op_q)
      2'b00:   alu = {1'b0, a_q} + {1'b0, b_q};
      2'b01:   alu = {1'b0, a_q} - {1'b0, b_q};
      2'b10:   alu = {1'b0, a_q & b_q};
      default: alu = {1'b0, a_q | b_q};
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt     <= '0;
      done_id <= '0;
      result  <= '0;
      carry   <= 1'b0;
      zero    <= 1'b0;
      ptr     <= '0;
      winner  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            a_q    <= a_in[int'(pick)*WIDTH +: WIDTH];
            b_q    <= b_in[int'(pick)*WIDTH +: WIDTH];
            op_q   <= op_in[int'(pick)*2 +: 2];
            gnt    <= N_REQ'(1) << pick;
            winner <= pick;
          end
        end
        EXEC: begin
          gnt     <= '0;
          result  <= alu[WIDTH-1:0];
          carry   <= alu[WIDTH];
          zero    <= (alu[WIDTH-1:0] == '0);
          done_id <= winner;
        end
        DONE: begin
          if (winner == ID_W'(N_REQ - 1)) ptr <= '0;
          else                            ptr <= winner + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Scoreboard bench for alu_rr_scheduler: a transaction-level model predicts grants
// and results; a negedge monitor compares everything the DUT presents.
module tb_alu_rr_scheduler;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [2*N-1:0] op_in;
  logic [N-1:0]   gnt;
  logic           busy;
  logic           done;
  logic [1:0]     done_id;
  logic [W-1:0]   result;
  logic           carry;
  logic           zero;

  alu_rr_scheduler #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .op_in(op_in),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
    .result(result), .carry(carry), .zero(zero)
  );

  typedef struct { int id; int cyc; } gexp_t;
  typedef struct { int id; int res; int cy; int zr; int cyc; } dexp_t;

  gexp_t gntq[$];
  dexp_t doneq[$];
  int    glog[$];
  int    glogcyc[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int m_phase  = 0;
  int m_ptr    = 0;
  int m_win    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s actual=timeout expected=event", name);
  endtask

  // Reference: idle/exec/done as a 3-cycle occupancy, winner chosen by rotating search.
  initial begin
    int w, a, b, op, res, cy;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_phase = 0;
        m_ptr   = 0;
        gntq.delete();
        doneq.delete();
      end else if (m_phase == 0) begin
        if (req != 0) begin
          w = -1;
          for (int k = 0; k < N; k++)
            if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
          a  = int'(a_in[w*W +: W]);
          b  = int'(b_in[w*W +: W]);
          op = int'(op_in[w*2 +: 2]);
          case (op)
            0: begin res = (a + b) % 256; cy = (a + b > 255) ? 1 : 0; end
            1: begin res = (a - b + 256) % 256; cy = (a < b) ? 1 : 0; end
            2: begin res = a & b; cy = 0; end
            default: begin res = a | b; cy = 0; end
          endcase
          gntq.push_back('{id: w, cyc: cyc});
          doneq.push_back('{id: w, res: res, cy: cy, zr: (res == 0) ? 1 : 0, cyc: cyc + 1});
          m_win   = w;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else begin
        m_phase = 0;
        m_ptr   = (m_win + 1) % N;
      end
    end
  end

  // Monitor: compares grants, completions and held outputs against the model.
  initial begin
    gexp_t g;
    dexp_t e;
    int h_res, h_cy, h_zr, h_id, gi;
    h_res = 0; h_cy = 0; h_zr = 0; h_id = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        h_res = 0; h_cy = 0; h_zr = 0; h_id = 0;
      end else begin
        checkOutput("busy", int'(busy), (m_phase != 0) ? 1 : 0);
        if (gnt != 0) begin
          gi = -1;
          for (int i = 0; i < N; i++) if (gnt[i]) gi = i;
          glog.push_back(gi);
          glogcyc.push_back(cyc);
          if (gntq.size() == 0) begin
            timeoutFail("gnt_unexpected");
          end else begin
            g = gntq.pop_front();
            checkOutput("gnt_onehot", int'(gnt), 1 << g.id);
            checkOutput("gnt_time", cyc, g.cyc);
          end
        end else if (gntq.size() > 0 && gntq[0].cyc <= cyc) begin
          void'(gntq.pop_front());
          timeoutFail("gnt_missing");
        end
        if (done) begin
          if (doneq.size() == 0) begin
            timeoutFail("done_unexpected");
          end else begin
            e = doneq.pop_front();
            checkOutput("done_id", int'(done_id), e.id);
            checkOutput("result", int'(result), e.res);
            checkOutput("carry", int'(carry), e.cy);
            checkOutput("zero", int'(zero), e.zr);
            checkOutput("done_time", cyc, e.cyc);
            h_res = e.res; h_cy = e.cy; h_zr = e.zr; h_id = e.id;
          end
        end else begin
          if (doneq.size() > 0 && doneq[0].cyc <= cyc) begin
            void'(doneq.pop_front());
            timeoutFail("done_missing");
          end
          checkOutput("hold_result", int'(result), h_res);
          checkOutput("hold_carry", int'(carry), h_cy);
          checkOutput("hold_zero", int'(zero), h_zr);
          checkOutput("hold_id", int'(done_id), h_id);
        end
      end
    end
  end

  task automatic scramble(input int i);
    a_in[i*W +: W]  = 8'($urandom_range(0, 255));
    b_in[i*W +: W]  = 8'($urandom_range(0, 255));
    op_in[i*2 +: 2] = 2'($urandom_range(0, 3));
  endtask

  // One cycle of requester behaviour: drop after grant, otherwise maybe raise.
  task automatic stepDriver(input bit hold_all, input int rate);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        req[i] = 1'b0;
        scramble(i);
      end else if (!req[i] && (hold_all || int'($urandom_range(0, 99)) < rate)) begin
        scramble(i);
        req[i] = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input logic [1:0] id, input int a, input int b, input int op,
                               output int waited);
    int k;
    @(negedge clk);
    a_in[id*W +: W]  = 8'(a);
    b_in[id*W +: W]  = 8'(b);
    op_in[id*2 +: 2] = 2'(op);
    req[id] = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!gnt[id] && waited < 30);
    if (!gnt[id]) timeoutFail("stim_gnt_wait");
    req[id] = 1'b0;
    scramble(int'(id));
    k = 0;
    while (!done && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (!done) timeoutFail("stim_done_wait");
  endtask

  task automatic logEntry(input string name, input int k, input int exp);
    if (k < glog.size()) checkOutput(name, glog[k], exp);
    else timeoutFail(name);
  endtask

  initial begin
    int waited, k;
    rst   = 1'b1;
    req   = '0;
    a_in  = '0;
    b_in  = '0;
    op_in = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_gnt", int'(gnt), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_result", int'(result), 0);
    checkOutput("rst_carry", int'(carry), 0);
    checkOutput("rst_zero", int'(zero), 0);
    checkOutput("rst_done_id", int'(done_id), 0);
    rst = 1'b0;

    applyStimulus(2'd0, 200, 100, 0, waited);
    checkOutput("add_latency", waited, 1);
    checkOutput("add_result", int'(result), 44);
    checkOutput("add_carry", int'(carry), 1);
    applyStimulus(2'd2, 5, 7, 1, waited);
    checkOutput("sub_borrow_result", int'(result), 8'hFE);
    checkOutput("sub_borrow_carry", int'(carry), 1);
    applyStimulus(2'd2, 9, 9, 1, waited);
    checkOutput("sub_zero_flag", int'(zero), 1);
    applyStimulus(2'd1, 8'hF0, 8'h3C, 2, waited);
    checkOutput("and_result", int'(result), 8'h30);
    applyStimulus(2'd1, 8'hF0, 8'h3C, 3, waited);
    checkOutput("or_result", int'(result), 8'hFC);

    // Requester 3 last serviced, so the pointer has wrapped to 0.
    applyStimulus(2'd3, 1, 2, 0, waited);
    glog.delete();
    glogcyc.delete();
    @(negedge clk);
    scramble(0);
    scramble(3);
    req = 4'b1001;
    repeat (10) stepDriver(1'b0, 0);
    logEntry("wrap_first", 0, 0);
    logEntry("wrap_second", 1, 3);

    glog.delete();
    glogcyc.delete();
    repeat (17) stepDriver(1'b1, 0);
    for (int i = 0; i < 5; i++) logEntry("rr_order", i, i % N);
    for (int i = 1; i < 5; i++)
      if (i < glogcyc.size()) checkOutput("rr_spacing", glogcyc[i] - glogcyc[i-1], 3);
    repeat (20) stepDriver(1'b0, 0);

    glog.delete();
    glogcyc.delete();
    @(negedge clk);
    scramble(2);
    req[2] = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!gnt[2] && k < 30);
    if (!gnt[2]) timeoutFail("late_gnt_wait");
    req[2] = 1'b0;
    scramble(0);
    req[0] = 1'b1;
    repeat (8) stepDriver(1'b0, 0);
    logEntry("late_first", 0, 2);
    logEntry("late_second", 1, 0);
    if (glogcyc.size() >= 2) checkOutput("late_spacing", glogcyc[1] - glogcyc[0], 3);

    repeat (300) stepDriver(1'b0, 25);
    repeat (20) stepDriver(1'b0, 0);

    // Abort an operation while it is executing.
    @(negedge clk);
    scramble(1);
    req[1] = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!gnt[1] && k < 30);
    if (!gnt[1]) timeoutFail("abort_gnt_wait");
    req = '0;
    rst = 1'b1;
    #1;
    checkOutput("abort_gnt", int'(gnt), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_result", int'(result), 0);
    checkOutput("abort_carry", int'(carry), 0);
    checkOutput("abort_zero", int'(zero), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    applyStimulus(2'd1, 3, 4, 0, waited);
    checkOutput("post_reset_latency", waited, 1);
    checkOutput("post_reset_result", int'(result), 7);

    repeat (5) @(negedge clk);
    checkOutput("gntq_empty", gntq.size(), 0);
    checkOutput("doneq_empty", doneq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
